note_sequencer: RTL
===================

# note_sequencer

Gameplay engine driven by the top-level game mode. It generates the falling-note sequence while the game is in RUN and scores player lane presses against each note. It freezes on PAUSE and reports `note_count` and a `song_done` pulse back to the mode controller, which uses them to auto-advance to FINISH. It sits between the mode FSM and the display/score drivers.

## Interface
Parameters:
- `NOTE_TOTAL`, default 41: number of notes per song. Range 1..63.
- `TEMPO_BASE`, default 16'd4000: clock cycles per beat at easy difficulty. Must be ≥ 4 and a multiple of 4.

Ports:
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `mode` in 3: game mode. 1=IDLE, 2=EDIT, 3=DIFF, 4=RUN, 5=PAUSE, 6=FINISH. Values 0 and 7 are treated as IDLE.
- `diff` in 2: difficulty select. 00=easy, 01=medium, 10/11=hard.
- `lane_btn` in 4: lane buttons, level, already synchronized.
- `note_lane` out 4: one-hot lane of the current note; 0 when no note is active.
- `note_count` out 6: notes completed.
- `score` out 8: hits, saturating at 255.
- `hit` out 1: one-cycle pulse, current note was hit.
- `miss` out 1: one-cycle pulse, current note was missed.
- `song_done` out 1: one-cycle pulse after the final note.

## Operation
Internal states: STOP, PLAY, HOLD, DONE.

Registers:
- `diff_reg`
- `tick` counter, 16 bit
- 4-bit LFSR `lfsr`
- `btn_prev`
- `got_hit` flag
- `spoiled` flag

Reset / STOP:
- All outputs 0.
- `diff_reg`=00, `tick`=0, `lfsr`=4'b1001, flags 0, `btn_prev`=0.

Mode handling:
- **mode IDLE or EDIT:** go to STOP. Clear `note_count`, `score`, `tick`, and both flags. Reload `lfsr`=4'b1001. `diff_reg` holds.
- **mode DIFF:** `diff_reg` <= `diff` every cycle. Counters hold. Go to STOP if not in DONE.
- **mode RUN:**
  - STOP/HOLD go to PLAY.
  - DONE stays DONE; the song does not restart until IDLE/EDIT.
- **mode PAUSE:** PLAY goes to HOLD. `tick`, `lfsr`, counts and flags freeze, and presses are ignored.
- **mode FINISH:** any state except DONE goes to STOP, but counts and score are retained (display shows them). No presses are evaluated.

Note generation:
- `note_lane` = one-hot(`lfsr[1:0]`) in PLAY and HOLD; 0 in STOP and DONE.
- LFSR advance: `lfsr` <= {`lfsr[2:0]`, `lfsr[3]`^`lfsr[2]`}.

Press detection (PLAY only):
- `rise` = `lane_btn` & ~`btn_prev`.
- `btn_prev` updates every cycle in all states, so a button held through PAUSE does not register on resume.
- If `rise` & `note_lane` ≠ 0 and `spoiled`=0, set `got_hit`.
- Any `rise` bit outside `note_lane` sets `spoiled`, which forces a miss. `spoiled` wins over `got_hit`, including when both occur in the same cycle.

Beat:
- Period P = `TEMPO_BASE` >> `diff_reg`, where hard uses a shift of 2.
- In PLAY, `tick` increments. On the edge where `tick`==P-1:
  - `tick` <= 0.
  - Evaluate the note using presses from the same cycle: hit if (`got_hit`|current hit rise) & ~(`spoiled`|current wrong rise), otherwise miss.
  - Pulse `hit` or `miss` for the next cycle.
  - `score` +1 on a hit, saturating at 255.
  - `note_count` +1.
  - Advance `lfsr` and clear both flags.
- If the incremented `note_count` == `NOTE_TOTAL`: pulse `song_done` in the same cycle as the final `hit`/`miss` and go to DONE.

## Timing
- All outputs are registered.
- First beat evaluation occurs P cycles after the first RUN cycle.
- `hit`/`miss`/`song_done` each last exactly 1 cycle.
- A mode change takes effect on the next edge. A RUN→PAUSE edge coinciding with `tick`==P-1 does not evaluate the beat.
- Reset mid-song returns all state to reset values asynchronously.

## Test plan
All scenarios use `TEMPO_BASE`=8 and `NOTE_TOTAL`=3.
1. **Reset, then RUN, easy.** Required: `note_lane`=4'b0010 on the first RUN cycle. With no presses, `miss` pulses at cycles 8, 16 and 24, lane sequence 0010→1000→0100. `song_done` fires with the third miss, `note_count`=3, `score`=0, and `note_lane`=0 afterward.
2. **Correct presses.** Rise `lane_btn`=0010 in note 1, 1000 in note 2, 0100 in note 3. Required: three `hit` pulses, `score`=3, `song_done` once.
3. **Wrong lane.** Press 0001 then 0010 during note 1. Required: `miss`, `score` unchanged.
4. **Pause.** PAUSE at `tick`=3 for 20 cycles, then RUN. Required: the beat fires 5 cycles after resume; a button held across the pause scores nothing.
5. **Difficulty.** `diff`=10 during DIFF, then RUN. Required: beats every 2 cycles.
6. **Return to IDLE after DONE.** Required: `note_count`=0, `score`=0, `lfsr` reseeded, and RUN restarts the song at lane 0010.

Source files
------------

// File: rtl/note_sequencer.sv
// Gameplay engine: walks an LFSR-driven note sequence at the selected tempo and scores
// rising-edge lane presses against each note, under control of the top-level game mode.
module note_sequencer #(
    parameter int unsigned NOTE_TOTAL = 41,
    parameter logic [15:0] TEMPO_BASE = 16'd4000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] mode,
    input  logic [1:0] diff,
    input  logic [3:0] lane_btn,
    output logic [3:0] note_lane,
    output logic [5:0] note_count,
    output logic [7:0] score,
    output logic       hit,
    output logic       miss,
    output logic       song_done
);

    typedef enum logic [1:0] {StStop, StPlay, StHold, StDone} state_t;

    localparam logic [5:0] NoteTotal = 6'(NOTE_TOTAL);
    localparam logic [3:0] LfsrSeed  = 4'b1001;

    state_t      state_q, state_d;
    logic [1:0]  diff_q, diff_d;
    logic [15:0] tick_q, tick_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [3:0]  btn_prev_q;
    logic        got_hit_q, got_hit_d;
    logic        spoiled_q, spoiled_d;
    logic [5:0]  count_q, count_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  lane_q, lane_d;
    logic        hit_q, hit_d, miss_q, miss_d, done_q, done_d;

    logic [15:0] period;
    logic [3:0]  rise;
    logic        hit_rise, wrong_rise;

    always_comb begin
        case (diff_q)
            2'b00:   period = TEMPO_BASE;
            2'b01:   period = TEMPO_BASE >> 1;
            default: period = TEMPO_BASE >> 2;
        endcase
    end

    assign rise       = lane_btn & ~btn_prev_q;
    assign hit_rise   = |(rise & lane_q);
    assign wrong_rise = |(rise & ~lane_q);

    always_comb begin
        state_d   = state_q;
        diff_d    = diff_q;
        tick_d    = tick_q;
        lfsr_d    = lfsr_q;
        got_hit_d = got_hit_q;
        spoiled_d = spoiled_q;
        count_d   = count_q;
        score_d   = score_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        done_d    = 1'b0;

        case (mode)
            3'd3: begin
                diff_d = diff;
                if (state_q != StDone) state_d = StStop;
            end
            3'd4: begin
                case (state_q)
                    StStop, StHold: state_d = StPlay;
                    StPlay: begin
                        if (wrong_rise) spoiled_d = 1'b1;
                        if (hit_rise && !spoiled_q) got_hit_d = 1'b1;
                        // >= rather than == : tick may sit past P-1 if difficulty rose mid-song
                        if (tick_q >= period - 16'd1) begin
                            tick_d    = 16'd0;
                            lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
                            got_hit_d = 1'b0;
                            spoiled_d = 1'b0;
                            count_d   = count_q + 6'd1;
                            if ((got_hit_q | hit_rise) & ~(spoiled_q | wrong_rise)) begin
                                hit_d = 1'b1;
                                if (score_q != 8'hff) score_d = score_q + 8'd1;
                            end else begin
                                miss_d = 1'b1;
                            end
                            if (count_d == NoteTotal) begin
                                done_d  = 1'b1;
                                state_d = StDone;
                            end
                        end else begin
                            tick_d = tick_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
            3'd5: begin
                if (state_q == StPlay) state_d = StHold;
            end
            3'd6: begin
                if (state_q != StDone) state_d = StStop;
            end
            default: begin
                state_d   = StStop;
                tick_d    = 16'd0;
                lfsr_d    = LfsrSeed;
                got_hit_d = 1'b0;
                spoiled_d = 1'b0;
                count_d   = 6'd0;
                score_d   = 8'd0;
            end
        endcase

        lane_d = (state_d == StPlay || state_d == StHold) ? (4'b0001 << lfsr_d[1:0]) : 4'b0000;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StStop;
            diff_q     <= 2'b00;
            tick_q     <= 16'd0;
            lfsr_q     <= LfsrSeed;
            btn_prev_q <= 4'b0000;
            got_hit_q  <= 1'b0;
            spoiled_q  <= 1'b0;
            count_q    <= 6'd0;
            score_q    <= 8'd0;
            lane_q     <= 4'b0000;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            diff_q     <= diff_d;
            tick_q     <= tick_d;
            lfsr_q     <= lfsr_d;
            btn_prev_q <= lane_btn;
            got_hit_q  <= got_hit_d;
            spoiled_q  <= spoiled_d;
            count_q    <= count_d;
            score_q    <= score_d;
            lane_q     <= lane_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
        end
    end

    assign note_lane  = lane_q;
    assign note_count = count_q;
    assign score      = score_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign song_done  = done_q;

endmodule
